// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and helpers for the configurable SPI master
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_e;

    // {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int cs_width(input int num_cs);
        return (num_cs <= 1) ? 1 : $clog2(num_cs);
    endfunction

endpackage

// File: rtl/spi_master_cfg_if.sv
// rtl/spi_master_cfg_if.sv - command/response handshake between bus bridge and SPI master
interface spi_master_cfg_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period timer, sclk register and leading/trailing edge strobes
module spi_sclk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             edge_en,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic             park_level,
    output logic             seg_end,
    output logic             lead_stb,
    output logic             trail_stb,
    output logic             sclk
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             edge_stb;

    // The counter only ever reaches div, so div = all-ones cannot wrap early.
    always_comb begin
        seg_end   = cnt_en && (cnt_q == div);
        edge_stb  = seg_end && edge_en;
        lead_stb  = edge_stb && (sclk_q == cpol);
        trail_stb = edge_stb && (sclk_q != cpol);

        cnt_d = cnt_q + 1'b1;
        if (!cnt_en || seg_end) begin
            cnt_d = '0;
        end

        sclk_d = park_level;
        if (edge_stb) begin
            sclk_d = ~sclk_q;
        end else if (run) begin
            sclk_d = sclk_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - SPI master with runtime mode, bit order, divider and one-hot chip selects
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NUM_CS = 4,
    parameter  int DIV_W  = 8,
    localparam int CS_W   = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [CS_W-1:0]   cs_sel,
    spi_master_cfg_if.slave   bus,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);

    localparam int BC_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                mosi_q, mosi_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic seg_end, lead_stb, trail_stb;
    logic edge_en, sample, drive;

    // Edges run from the end of SETUP until the last trailing edge; the
    // final XFER half-period then idles sclk at CPOL.
    assign edge_en = (state_q == SETUP) ||
                     ((state_q == XFER) && (bit_cnt_q != BC_W'(DATA_W)));

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .cnt_en     (state_q != IDLE),
        .edge_en    (edge_en),
        .run        (state_q == XFER),
        .div        (div_q),
        .cpol       (cpol_q),
        .park_level ((state_q == IDLE) ? cfg_cpol : cpol_q),
        .seg_end    (seg_end),
        .lead_stb   (lead_stb),
        .trail_stb  (trail_stb),
        .sclk       (spi_sclk)
    );

    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsb_d       = lsb_q;
        div_d       = div_q;
        cs_d        = cs_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        mosi_d      = mosi_q;
        bit_cnt_d   = bit_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        sample = cpha_q ? trail_stb : lead_stb;
        drive  = cpha_q ? lead_stb
                        : (trail_stb && (bit_cnt_q != BC_W'(DATA_W - 1)));

        if (sample) begin
            rx_d = lsb_q ? {spi_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], spi_miso};
        end
        if (drive) begin
            mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        end
        if (trail_stb) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = SETUP;
                    cpol_d    = cfg_cpol;
                    cpha_d    = cfg_cpha;
                    lsb_d     = cfg_lsb_first;
                    div_d     = cfg_div;
                    cs_d      = cs_sel;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = bus.cmd_data;
                    // CPHA=0 slaves sample on the first edge, so bit one goes out now.
                    if (!cfg_cpha) begin
                        mosi_d = cfg_lsb_first ? bus.cmd_data[0] : bus.cmd_data[DATA_W-1];
                        tx_d   = cfg_lsb_first ? (bus.cmd_data >> 1) : (bus.cmd_data << 1);
                    end
                end
            end
            SETUP: if (seg_end) state_d = XFER;
            XFER:  if (seg_end && !edge_en) state_d = HOLD;
            HOLD: begin
                if (seg_end) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                end
            end
            DONE:    if (seg_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cs_n_d = '1;
        if ((state_d == SETUP) || (state_d == XFER) || (state_d == HOLD)) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (cs_d == CS_W'(i)) begin
                    cs_n_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            div_q       <= '0;
            cs_q        <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            mosi_q      <= 1'b0;
            bit_cnt_q   <= '0;
            cs_n_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsb_q       <= lsb_d;
            div_q       <= div_d;
            cs_q        <= cs_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            mosi_q      <= mosi_d;
            bit_cnt_q   <= bit_cnt_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign spi_mosi      = mosi_q;
    assign spi_cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - directed scoreboard bench for spi_master_cfg
module tb_spi_master_cfg;
    import spi_pkg::*;

    localparam int DATA_W = 32;
    localparam int NUM_CS = 5;
    localparam int DIV_W  = 8;
    localparam int CS_W   = cs_width(NUM_CS);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_cpol = 1'b0;
    logic              cfg_cpha = 1'b0;
    logic              cfg_lsb_first = 1'b0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [CS_W-1:0]   cs_sel = '0;
    logic              spi_sclk, spi_mosi, spi_miso;
    logic [NUM_CS-1:0] spi_cs_n;

    logic              loopback = 1'b1;
    logic              slave_en = 1'b0;
    logic              slave_bit = 1'b0;
    logic [31:0]       slave_word = '0;
    int                slave_idx = 0;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          last_rsp_cyc = -1;
    logic [31:0] sb[$];

    spi_master_cfg_if #(.DATA_W(DATA_W)) bus ();

    spi_master_cfg #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_cpol      (cfg_cpol),
        .cfg_cpha      (cfg_cpha),
        .cfg_lsb_first (cfg_lsb_first),
        .cfg_div       (cfg_div),
        .cs_sel        (cs_sel),
        .bus           (bus.slave),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_cs_n      (spi_cs_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign spi_miso = loopback ? spi_mosi : slave_bit;

    // LSB-first CPOL=0/CPHA=1 slave: presents its next bit on each rising edge.
    always @(posedge spi_sclk) begin
        if (slave_en && slave_idx < 32) begin
            slave_bit = slave_word[slave_idx];
            slave_idx++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            last_rsp_cyc = cyc;
            chk("rsp_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) chk("rsp_data", 64'(bus.rsp_data), 64'(sb.pop_front()));
        end
    end

    // Call on a negedge; returns one tick after the accepting posedge.
    task automatic issue(input logic [31:0] d, input logic [31:0] exp, input bit push,
                         input bit keep, output int t);
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        if (push) sb.push_back(exp);
        t = -1;
        for (int k = 0; k < 2000; k++) begin
            if (bus.cmd_ready) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("accept_seen", 64'(t >= 0), 64'd1);
        @(posedge clk);
        #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_in_time", 64'(ok), 64'd1);
    endtask

    task automatic set_cfg(input logic [1:0] mode, input bit lsb, input int div, input int cs);
        {cfg_cpol, cfg_cpha} = mode;
        cfg_lsb_first = lsb;
        cfg_div = DIV_W'(div);
        cs_sel = CS_W'(cs);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int t, t2, edges, bad_p, bad_m, first_edge, last_edge, cs_bad;
        logic prev_s, prev_m;
        logic [NUM_CS-1:0] cs_seen;

        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_sclk", 64'(spi_sclk), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_cs_n", 64'(spi_cs_n), 64'h1F);
        rst = 1'b0;

        // 1: mode 0, MSB-first, div 0, CS0
        set_cfg(MODE0, 0, 0, 0);
        issue(32'hA5A50F0F, 32'hA5A50F0F, 1, 0, t);
        repeat (5) @(negedge clk);
        chk("t1_cs_n", 64'(spi_cs_n), 64'h1E);
        wait_done();
        chk("t1_rsp_cycle", 64'(last_rsp_cyc), 64'(t + 67));

        // 2: mode 3, div 3, CS2; MOSI must only move on falling sclk
        set_cfg(MODE3, 0, 3, 2);
        chk("t2_sclk_idle", 64'(spi_sclk), 64'd1);
        issue(32'h3C5A96E0, 32'h3C5A96E0, 1, 0, t);
        prev_s = spi_sclk; prev_m = spi_mosi;
        edges = 0; bad_p = 0; bad_m = 0; first_edge = -1; last_edge = -1; cs_seen = '0;
        for (int k = 0; k < 400 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (spi_sclk != prev_s) begin
                edges++;
                if (last_edge < 0) first_edge = cyc;
                else if (cyc - last_edge != 4) bad_p++;
                last_edge = cyc;
            end
            if (spi_mosi != prev_m && !(prev_s && !spi_sclk)) bad_m++;
            if (cyc == t + 10) cs_seen = spi_cs_n;
            prev_s = spi_sclk; prev_m = spi_mosi;
        end
        chk("t2_cs_n", 64'(cs_seen), 64'h1B);
        chk("t2_first_edge", 64'(first_edge), 64'(t + 5));
        chk("t2_edge_count", 64'(edges), 64'd64);
        chk("t2_half_period", 64'(bad_p), 64'd0);
        chk("t2_mosi_on_fall", 64'(bad_m), 64'd0);
        wait_done();
        chk("t2_rsp_cycle", 64'(last_rsp_cyc), 64'(t + 1 + 66 * 4));

        // 3: mode 1, LSB-first, slave answers 0x80000000
        loopback = 1'b0; slave_word = 32'h80000000; slave_idx = 0; slave_bit = 1'b0; slave_en = 1'b1;
        set_cfg(MODE1, 1, 1, 0);
        issue(32'h00000001, 32'h80000000, 1, 0, t);
        for (int k = 0; k < 20; k++) begin
            if (spi_sclk) break;
            @(negedge clk);
        end
        chk("t3_first_mosi", 64'(spi_mosi), 64'd1);
        wait_done();
        slave_en = 1'b0; loopback = 1'b1;

        // 4: back-to-back with cmd_valid held high, H = 2
        set_cfg(MODE0, 0, 1, 3);
        issue(32'hDEADBEEF, 32'hDEADBEEF, 1, 1, t);
        bus.cmd_data = 32'h0123ABCD;
        @(negedge clk);
        issue(32'h0123ABCD, 32'h0123ABCD, 1, 0, t2);
        chk("t4_second_accept", 64'(t2), 64'(t + 1 + 67 * 2));
        chk("t4_gap_after_rsp", 64'(t2 - last_rsp_cyc), 64'd2);
        wait_done();

        // 5: reset on the 10th sclk edge, then a clean transfer
        set_cfg(MODE0, 0, 0, 0);
        issue(32'hFFFF0000, 32'h0, 0, 0, t);
        prev_s = spi_sclk; edges = 0;
        for (int k = 0; k < 100 && edges < 10; k++) begin
            @(negedge clk);
            if (spi_sclk != prev_s) edges++;
            prev_s = spi_sclk;
        end
        rst = 1'b1;
        #1;
        chk("t5_cs_n", 64'(spi_cs_n), 64'h1F);
        chk("t5_sclk", 64'(spi_sclk), 64'd0);
        chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        issue(32'h12345678, 32'h12345678, 1, 0, t);
        wait_done();

        // 6: config changes mid-transfer do not disturb it; cs_sel = NUM_CS selects nothing
        set_cfg(MODE0, 0, 2, 1);
        issue(32'h5A5AC3C3, 32'h5A5AC3C3, 1, 0, t);
        repeat (20) @(negedge clk);
        cfg_cpol = 1'b1; cfg_div = 8'd7; cs_sel = 3'd5;
        repeat (5) @(negedge clk);
        chk("t6_cs_n_kept", 64'(spi_cs_n), 64'h1D);
        wait_done();
        chk("t6_rsp_cycle", 64'(last_rsp_cyc), 64'(t + 1 + 66 * 3));
        @(negedge clk);
        issue(32'h0F1E2D3C, 32'h0F1E2D3C, 1, 0, t);
        cs_bad = 0;
        for (int k = 0; k < 700 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (spi_cs_n != '1) cs_bad++;
        end
        chk("t6_no_cs", 64'(cs_bad), 64'd0);
        wait_done();
        chk("t6_rsp_cycle_h8", 64'(last_rsp_cyc), 64'(t + 1 + 66 * 8));

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
